// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits LSB-first, optional even
// parity, stop bit; delivers words through a one-deep valid/ready buffer with sticky error flags.
module sipo_frame_rx #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             frame_err,
  output logic             par_err,
  output logic             overrun,
  input  logic             err_clr
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;
  localparam int         CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             par_bad;
  logic             stop_edge, consume, good, load, fe_set, pe_set, ov_set;

  always_comb begin
    stop_edge = (state == STOP);
    consume   = p_valid & p_ready;
    fe_set    = stop_edge & s_in;
    pe_set    = stop_edge & ~s_in & par_bad;
    good      = stop_edge & ~s_in & ~par_bad;
    // A consume on the stop edge frees the buffer for the new word in the same cycle.
    load      = good & (~p_valid | consume);
    ov_set    = good & p_valid & ~p_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s_in) begin
          state   <= DATA;
          cnt     <= '0;
          par_bad <= 1'b0;
        end
        DATA: begin
          // Shifting right places the first (LSB) bit at bit 0 after WIDTH shifts.
          shreg <= {s_in, shreg[WIDTH-1:1]};
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) state <= (PARITY_EN != 0) ? PARITY : STOP;
        end
        PARITY: begin
          par_bad <= s_in ^ (^shreg);
          state   <= STOP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_out     <= '0;
      p_valid   <= 1'b0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        p_out   <= shreg;
        p_valid <= 1'b1;
      end else if (consume) begin
        p_valid <= 1'b0;
      end
      frame_err <= fe_set | (frame_err & ~err_clr);
      par_err   <= pe_set | (par_err & ~err_clr);
      overrun   <= ov_set | (overrun & ~err_clr);
    end
  end
endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: queue-based frame model checked every cycle, directed literal
// checks, randomized frames/noise, and a PARITY_EN=0 instance for the no-parity case.
module tb_sipo_frame_rx;
  localparam int W  = 8;
  localparam int FL = 2 + W + 1;

  logic clk = 1'b0, rst = 1'b0;
  logic s_in = 1'b0, p_ready = 1'b0, err_clr = 1'b0;
  logic [W-1:0] p_out;
  logic p_valid, frame_err, par_err, overrun;

  logic s_in0 = 1'b0, p_ready0 = 1'b0, err_clr0 = 1'b0;
  logic [W-1:0] p_out0;
  logic p_valid0, frame_err0, par_err0, overrun0;

  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  sipo_frame_rx #(.WIDTH(W), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .p_out(p_out), .p_valid(p_valid),
    .p_ready(p_ready), .frame_err(frame_err), .par_err(par_err),
    .overrun(overrun), .err_clr(err_clr));

  sipo_frame_rx #(.WIDTH(W), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .s_in(s_in0), .p_out(p_out0), .p_valid(p_valid0),
    .p_ready(p_ready0), .frame_err(frame_err0), .par_err(par_err0),
    .overrun(overrun0), .err_clr(err_clr0));

  // Model: collect the sampled bits of a frame, judge the whole frame at its last bit.
  bit           q[$];
  logic [W-1:0] m_out;
  bit           m_val, m_fe, m_pe, m_ov;

  always @(posedge clk) begin
    bit fe_s, pe_s, ov_s, ld, take;
    logic [W-1:0] w;
    if (!rst) begin
      q.delete();
      m_out = '0; m_val = 0; m_fe = 0; m_pe = 0; m_ov = 0;
    end else begin
      fe_s = 0; pe_s = 0; ov_s = 0; ld = 0; w = '0;
      take = m_val && p_ready;
      if (q.size() != 0 || s_in) q.push_back(s_in);
      if (q.size() == FL) begin
        for (int i = 0; i < W; i++) w[i] = q[1 + i];
        if (q[FL-1])              fe_s = 1;
        else if (q[W+1] != ^w)    pe_s = 1;
        else if (m_val && !take)  ov_s = 1;
        else                      ld = 1;
        q.delete();
      end
      if (ld) begin m_out = w; m_val = 1; end
      else if (take) m_val = 0;
      m_fe = fe_s | (m_fe & !err_clr);
      m_pe = pe_s | (m_pe & !err_clr);
      m_ov = ov_s | (m_ov & !err_clr);
    end
  end

  always @(negedge clk) begin
    logic [W+3:0] got, exp;
    got = {p_out, p_valid, frame_err, par_err, overrun};
    exp = rst ? {m_out, m_val, m_fe, m_pe, m_ov} : '0;
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL cycle_model t=%0t got out=%h v=%b fe=%b pe=%b ov=%b exp out=%h v=%b fe=%b pe=%b ov=%b",
        $time, got[W+3:4], got[3], got[2], got[1], got[0],
        exp[W+3:4], exp[3], exp[2], exp[1], exp[0]);
    end
  end

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step(input logic b, input logic rdy, input logic clr);
    s_in = b; p_ready = rdy; err_clr = clr;
    @(posedge clk); #1;
  endtask

  task automatic step0(input logic b, input logic rdy);
    s_in0 = b; p_ready0 = rdy;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] w, input logic pb, input logic sb,
                      input logic rdy, input bit chk_lat);
    step(1'b1, rdy, 1'b0);
    for (int i = 0; i < W; i++) step(w[i], rdy, 1'b0);
    step(pb, rdy, 1'b0);
    if (chk_lat) chk("latency_edge10_valid", {7'd0, p_valid}, 8'd0);
    step(sb, rdy, 1'b0);
  endtask

  task automatic send_rand();
    logic [W-1:0] w;
    logic pb, sb;
    w  = W'($urandom);
    pb = (^w) ^ ($urandom_range(0, 7) == 0);
    sb = ($urandom_range(0, 7) == 0);
    step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    for (int i = 0; i < W; i++)
      step(w[i], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    step(pb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    step(sb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
  endtask

  initial begin
    logic [W-1:0] v;
    step(0, 0, 0); step(0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0);

    // Reset in the middle of a frame, then a clean 0x3C frame.
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(1, 0, 0);
    rst = 1'b0;
    step(1, 0, 0);
    chk("reset_outputs", {p_out[W-1:4], p_valid, frame_err, par_err, overrun} | p_out, 8'd0);
    step(1, 0, 0);
    rst = 1'b1;
    step(0, 0, 0); step(0, 0, 0);
    send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("latency_edge11_valid", {7'd0, p_valid}, 8'd1);
    chk("reset_frame_word", p_out, 8'h3C);
    step(0, 1, 0);

    // Clean frame with consumer ready.
    send(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("a5_valid", {7'd0, p_valid}, 8'd1);
    chk("a5_word", p_out, 8'hA5);
    step(0, 1, 0);
    chk("a5_consumed", {7'd0, p_valid}, 8'd0);
    chk("a5_flags", {5'd0, frame_err, par_err, overrun}, 8'd0);

    // Back-to-back frames into a full buffer.
    send(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("overrun_flag", {7'd0, overrun}, 8'd1);
    chk("overrun_word_kept", p_out, 8'h01);
    step(0, 1, 0);
    chk("overrun_drained", {7'd0, p_valid}, 8'd0);
    chk("overrun_word_after", p_out, 8'h01);
    step(0, 0, 1);
    chk("overrun_clear", {7'd0, overrun}, 8'd0);

    send(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("par_err_flag", {7'd0, par_err}, 8'd1);
    chk("par_err_no_valid", {7'd0, p_valid}, 8'd0);

    send(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("frame_err_flag", {7'd0, frame_err}, 8'd1);
    chk("frame_err_no_valid", {7'd0, p_valid}, 8'd0);
    step(0, 0, 1);
    chk("err_clr_flags", {5'd0, frame_err, par_err, overrun}, 8'd0);

    // No-parity instance: reload on the consuming edge.
    v = 8'h11;
    step0(1, 0);
    for (int i = 0; i < W; i++) step0(v[i], 0);
    step0(0, 0);
    chk("np_first_word", p_out0, 8'h11);
    step0(1, 0);
    for (int i = 0; i < W; i++) step0(1'b1, 0);
    step0(0, 1);
    chk("np_valid_kept", {7'd0, p_valid0}, 8'd1);
    chk("np_word_ff", p_out0, 8'hFF);
    chk("np_no_flags", {5'd0, frame_err0, par_err0, overrun0}, 8'd0);
    step0(0, 0);

    // Randomized traffic: frames with occasional bad parity/stop, line noise, resets.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 12) send_rand();
      else if (r < 19) begin
        for (int k = 0; k < int'($urandom_range(1, 6)); k++)
          step(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
      end else begin
        rst = 1'b0;
        step(1'($urandom_range(0, 1)), 0, 0);
        rst = 1'b1;
        step(0, 0, 0);
      end
    end
    step(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
